// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider with its sequencing FSM.
// One quotient bit per ITER cycle; done pulses once when results are valid.
// Optional feature macro: SIGNED_DIV_EN (two's-complement mode via is_signed, adds FIX state).
//
// state | meaning
// IDLE  | waiting for start; results held
// LOAD  | clear partial remainder, load magnitudes, arm counter
// ITER  | one shift/compare/subtract step per cycle
// FIX   | sign correction of quotient/remainder (SIGNED_DIV_EN only)
// DONE  | done pulse visible, results valid
module div_seq_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_sh, r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             r_ge;

    // R never exceeds the divisor, so its top bit and the top bit of the
    // step result are structurally zero; is_signed is dead in unsigned builds.
    logic spare_unused;
    assign spare_unused = ^{is_signed, r_q[WIDTH], r_nx[WIDTH], sgn_q, neg_q};

    // One restoring step on the full WIDTH+1 bit partial remainder
    always_comb begin
        r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_ge = (r_sh >= {1'b0, dvs_q});
        r_nx = r_ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
        q_nx = {q_q[WIDTH-2:0], r_ge};
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
`ifdef SIGNED_DIV_EN
                    sgn_d   = is_signed;
`else
                    sgn_d   = 1'b0;
`endif
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                r_d   = '0;
                cnt_d = CNT_W'(WIDTH);
                if (dvs_q == '0) begin
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    q_d     = dvd_q;
                    neg_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                    // Work on magnitudes; the most negative value maps to itself,
                    // which is its correct unsigned magnitude.
                    if (sgn_q && dvd_q[WIDTH-1]) q_d = -dvd_q;
                    if (sgn_q && dvs_q[WIDTH-1]) dvs_d = -dvs_q;
                    neg_d   = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
`endif
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                r_d   = r_nx;
                q_d   = q_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
                    if (sgn_q) begin
                        state_d = S_FIX;
                    end else begin
                        quot_d  = q_nx;
                        rem_d   = r_nx[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
`else
                    quot_d  = q_nx;
                    rem_d   = r_nx[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIX: begin
                quot_d  = neg_q ? -q_q : q_q;
                rem_d   = dvd_q[WIDTH-1] ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vectors with a scoreboard queue and a done monitor.
module tb_div_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .is_signed(is_signed), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           t_edge;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("done_without_request", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'b0, quotient}, {16'b0, e.q});
                chk("remainder", {16'b0, remainder}, {16'b0, e.r});
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                chk("latency", (cyc + 1) - e.t_edge, e.lat);
                chk("busy_with_done", {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat);
        exp_t e;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        e.q = eq; e.r = er; e.dbz = edbz; e.t_edge = cyc + 1; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quotient", {16'b0, quotient}, 32'd0);
        chk("rst_remainder", {16'b0, remainder}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        rst = 1'b1;

        issue(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, W + 2);
        drain();
        @(negedge clk);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("quotient_held", {16'b0, quotient}, 32'd14);

        issue(16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0, W + 2);
        drain();
        issue(16'd3, 16'hFFFF, 1'b0, 16'd0, 16'd3, 1'b0, W + 2);
        drain();
        issue(16'd0, 16'd5, 1'b0, 16'd0, 16'd0, 1'b0, W + 2);
        drain();

        issue(16'd5, 16'd0, 1'b0, 16'hFFFF, 16'd5, 1'b1, 2);
        drain();
        issue(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, W + 2);
        drain();

        // Start re-pulsed mid-operation must be ignored
        issue(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, W + 2);
        repeat (3) @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // Reset in the middle of ITER
        issue(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, W + 2);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_quotient", {16'b0, quotient}, 32'd0);
        chk("abort_remainder", {16'b0, remainder}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        issue(16'd200, 16'd13, 1'b0, 16'd15, 16'd5, 1'b0, W + 2);
        drain();

`ifdef SIGNED_DIV_EN
        issue(16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, W + 3);
        drain();
        issue(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0, 1'b0, W + 3);
        drain();
        issue(16'd7, 16'hFFFE, 1'b1, 16'hFFFD, 16'd1, 1'b0, W + 3);
        drain();
        issue(16'hFFF9, 16'd0, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 2);
        drain();
        issue(16'hFFF9, 16'd2, 1'b0, 16'h7FFC, 16'd1, 1'b0, W + 2);
        drain();
`else
        issue(16'hFFF9, 16'd2, 1'b1, 16'h7FFC, 16'd1, 1'b0, W + 2);
        drain();
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
